// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed 8N1 UART transmitter.
package fifo_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int unsigned BAUD_W = 16;

endpackage

// File: rtl/fifo_uart_tx_baud_div.sv
// Bit-period divider: tick marks the last clock of each DIV-clock bit period.
module baud_div
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned DIV = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam logic [BAUD_W-1:0] RELOAD = BAUD_W'(DIV - 1);

  logic [BAUD_W-1:0] cnt;

  assign tick = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Serialises bytes from the FIFO read port as 8N1 frames; back-to-back when data is queued.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       empty,
  input  logic [7:0] din,
  input  logic       cts,
  output logic       rd,
  output logic       txd,
  output logic       busy
);

  state_t     state;
  logic [7:0] shift;
  logic [2:0] bitcnt;
  logic       tick;
  logic       ld;

  // A new frame may start from idle or on the last clock of a stop bit.
  assign ld = ((state == IDLE) || ((state == STOP) && tick)) && !empty && cts && !rst;
  assign rd = ld;

  baud_div #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (ld),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shift  <= '0;
      bitcnt <= '0;
      txd    <= 1'b1;
      busy   <= 1'b0;
    end else if (ld) begin
      shift <= din;
      state <= START;
      txd   <= 1'b0;
      busy  <= 1'b1;
    end else if (tick) begin
      case (state)
        START: begin
          txd    <= shift[0];
          shift  <= {1'b0, shift[7:1]};
          bitcnt <= 3'd7;
          state  <= DATA;
        end
        DATA: begin
          if (bitcnt != 3'd0) begin
            txd    <= shift[0];
            shift  <= {1'b0, shift[7:1]};
            bitcnt <= bitcnt - 3'd1;
          end else begin
            txd   <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          txd   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          txd <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: DIV=4 instance for functional cases, DIV=434 instance for bit timing.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       empty, cts;
  logic [7:0] din;
  logic       rd, txd, busy;

  logic       s_empty, s_cts;
  logic [7:0] s_din;
  logic       s_rd, s_txd, s_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DIV(4)) dut (
    .clk(clk), .rst(rst), .empty(empty), .din(din), .cts(cts),
    .rd(rd), .txd(txd), .busy(busy)
  );

  fifo_uart_tx #(.DIV(434)) dut_slow (
    .clk(clk), .rst(rst), .empty(s_empty), .din(s_din), .cts(s_cts),
    .rd(s_rd), .txd(s_txd), .busy(s_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  logic [9:0] f0, f1;

  initial begin
    rst = 1'b1; empty = 1'b1; cts = 1'b1; din = 8'h00;
    s_empty = 1'b1; s_cts = 1'b1; s_din = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle with empty FIFO
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check("idle_txd", txd, 1);
      check("idle_busy", busy, 0);
      check("idle_rd", rd, 0);
    end

    // Single byte 0xA5
    din = 8'hA5; empty = 1'b0;
    #1 check("a5_rd", rd, 1);
    f0 = 10'b1_1010_0101_0;
    @(negedge clk);
    empty = 1'b1;
    for (int k = 0; k < 40; k++) begin
      check("a5_txd", txd, f0[k/4]);
      check("a5_busy", busy, 1);
      check("a5_rd_low", rd, 0);
      @(negedge clk);
    end
    check("a5_end_busy", busy, 0);
    check("a5_end_txd", txd, 1);

    // Back-to-back 0x00 then 0xFF
    @(negedge clk);
    din = 8'h00; empty = 1'b0;
    #1 check("b2b_rd0", rd, 1);
    f0 = frame_of(8'h00);
    f1 = frame_of(8'hFF);
    @(negedge clk);
    din = 8'hFF;
    for (int k = 0; k < 80; k++) begin
      if (k == 40) empty = 1'b1;
      check("b2b_txd", txd, (k < 40) ? f0[k/4] : f1[(k-40)/4]);
      check("b2b_rd", rd, (k == 39) ? 1 : 0);
      check("b2b_busy", busy, 1);
      @(negedge clk);
    end
    check("b2b_end_busy", busy, 0);

    // Flow control
    cts = 1'b0; din = 8'h3C; empty = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("cts_hold_rd", rd, 0);
      check("cts_hold_txd", txd, 1);
    end
    cts = 1'b1;
    #1 check("cts_rise_rd", rd, 1);
    f0 = frame_of(8'h3C);
    @(negedge clk);
    empty = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k == 12) cts = 1'b0;
      check("cts_txd", txd, f0[k/4]);
      check("cts_busy", busy, 1);
      @(negedge clk);
    end
    check("cts_end_busy", busy, 0);
    check("cts_end_txd", txd, 1);
    cts = 1'b1;

    // Reset during data bit 3
    @(negedge clk);
    din = 8'h96; empty = 1'b0;
    #1 check("rst_rd0", rd, 1);
    f0 = frame_of(8'h96);
    @(negedge clk);
    empty = 1'b1;
    for (int k = 0; k < 17; k++) begin
      check("rst_pre_txd", txd, f0[k/4]);
      @(negedge clk);
    end
    rst = 1'b1; din = 8'h5A; empty = 1'b0;
    #1 check("rst_rd_during", rd, 0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    #1 check("rst_restart_rd", rd, 1);
    f0 = frame_of(8'h5A);
    @(negedge clk);
    empty = 1'b1;
    for (int k = 0; k < 40; k++) begin
      check("rst_new_txd", txd, f0[k/4]);
      check("rst_new_busy", busy, 1);
      @(negedge clk);
    end
    check("rst_new_end_busy", busy, 0);

    // DIV=434 timing
    s_din = 8'h55; s_empty = 1'b0;
    #1 check("slow_rd", s_rd, 1);
    f0 = frame_of(8'h55);
    @(negedge clk);
    s_empty = 1'b1;
    for (int k = 0; k <= 4340; k++) begin
      if (k == 0 || k == 433 || k == 434 || k == 867 || k == 868 ||
          k == 3471 || k == 3472 || k == 3905 || k == 3906 || k == 4339)
        check("slow_txd", s_txd, f0[k/434]);
      if (k == 4339) check("slow_busy_last", s_busy, 1);
      if (k == 4340) begin
        check("slow_busy_end", s_busy, 0);
        check("slow_txd_end", s_txd, 1);
      end
      if (k == 10) check("slow_rd_once", s_rd, 0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Serial transmit stage directly downstream of the 8-entry FIFO addressing block. It watches the FIFO empty flag and reads the byte presented by the external FIFO storage at the current read address.
- It issues the FIFO read confirm and serialises each byte as an asynchronous 8N1 frame on a single output line.
- Sits between the control-processor byte queue and the serial port pin.

Parameters:
- DIV, 434, clocks per bit period (434 gives 115200 baud at 50 MHz); legal range 2..65535.

Ports:
- clk  input  1  master clock
- rst  input  1  master reset; synchronous, active-high
- empty  input  1  FIFO empty flag
- din  input  8  FIFO read data; combinational from storage at the FIFO read address, valid whenever empty=0
- cts  input  1  clear-to-send, active-high; sampled only when a new frame may start
- rd  output  1  FIFO read confirm; combinational, one-cycle pulse per byte taken
- txd  output  1  serial data, registered, idle high
- busy  output  1  frame in progress, registered

Behaviour:
- Reset values (next clock edge with rst=1, overriding everything):
  - txd=1, busy=0, state=IDLE, baud counter=0, bit counter=0, shift register=0.
  - rd=0 while rst=1.
- States are IDLE, START, DATA and STOP.
- Load condition: ld = (state==IDLE | (state==STOP & baud counter==0)) & ~empty & cts & ~rst.
  - rd = ld, asserted exactly one cycle per byte.
  - The FIFO advances its read address on that same edge.
- On ld:
  - din is captured into the shift register.
  - state becomes START, the baud counter loads DIV-1, txd goes to 0 on the next edge, and busy goes to 1.
  - Latency is one clock from the first cycle with ld=1 to the txd falling edge.
- Bit periods: every bit lasts exactly DIV clocks. The baud counter counts down, and the bit boundary is the cycle where the counter is 0; on that cycle the counter reloads DIV-1.
- START: at the boundary, go to DATA. txd takes shift[0], the register shifts right, and the bit counter is set to 7.
- DATA: data is sent LSB first, eight bits. At each boundary:
  - If bit counter != 0, output the next bit and decrement the counter.
  - If bit counter == 0, go to STOP with txd=1.
- STOP: lasts one bit period with txd=1. At the boundary:
  - If ld, start the next frame immediately with no idle gap (back-to-back frames).
  - Otherwise go to IDLE with busy=0; txd stays 1.
- Frame length is exactly 10*DIV clocks, start-bit edge to start-bit edge, when back-to-back.
- cts:
  - cts is checked only at frame start.
  - Deasserting cts mid-frame does not stop the frame in progress; the current frame completes.
  - While cts=0, no rd is issued and txd stays 1.
- empty is ignored except in the load condition. A byte arriving mid-frame waits until the STOP boundary.
- Reset mid-frame:
  - The frame is abandoned and the partial byte is lost.
  - No rd is issued during reset.
  - txd returns high on the reset edge.
- Counter widths: the baud counter is 16 bits, compared against DIV-1 truncated to 16 bits; the bit counter is 3 bits.
- No X on txd, busy or rd after the first reset edge.

Decomposition:
- The shared include file holds the state encodings (IDLE=0, START=1, DATA=2, STOP=3) and the baud counter width constant (16). The state machine, shift register and bit counter stay in fifo_uart_tx.
- One sub-module, baud_div:
  - Inputs are clk, rst and a restart pulse (driven by ld); output is a tick (baud counter==0).
  - Parameter DIV.
  - restart forces the reload to DIV-1; reset clears the counter to 0.

Test Plan (DIV=4 unless stated):
- Reset, empty=1, cts=1 for 100 clocks -> txd=1, busy=0, rd=0 on every cycle.
- empty falls with din=0xA5, cts=1 -> rd high for exactly 1 cycle. Starting one clock later, txd emits 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks (40 total). busy is high for 40 clocks, then low.
- Two queued bytes, 0x00 then 0xFF, with empty held low through the second rd -> rd pulses exactly 40 clocks apart. The second start bit immediately follows the 4-clock stop bit, and txd is never high for more than 4 clocks between frames.
- cts=0 with empty=0 for 50 clocks -> no rd and txd=1. cts rises -> rd in that cycle and txd falls the next clock. Dropping cts at frame clock 12 -> the frame still completes in full.
- rst pulsed for 1 clock during data bit 3 -> txd=1 and busy=0 after that edge, rd=0 during reset. With empty=0 after release, a new frame starts one clock later and sends the current din.
- DIV=434, din=0x55 -> each bit lasts exactly 434 clocks and the frame lasts 4340 clocks; verify at the first and last bit edges.
